ibex_fpu_sequencer: RTL
=======================

# ibex_fpu_sequencer

Issue sequencer for the `ibex_FPU` arithmetic datapath. It accepts FP operation requests from the decode stage through a valid/ready handshake and buffers them in a small in-order queue. It drives one operation at a time onto the FPU operand and opcode inputs, holding each for that operation's fixed latency. The FPU's register-file write strobes are gated so that multi-cycle operations (DIV, SQRT) commit exactly once, on their final cycle.

## Interface
Parameters:
- `Depth`, 2: request queue entries; power of two, ≥2.
- `DivLatency`, 8: cycles `FPU_DIV` is held on the datapath; ≥1.
- `SqrtLatency`, 8: cycles `FPU_SQRT` is held on the datapath; ≥1.

Ports. One clock; reset is synchronous and active-low.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `flush_i`  in  1  discard queue and abort the operation in flight.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  queue can accept.
- `req_op_i`  in  `fpu_op_e`  operation.
- `req_rm_i`  in  3  rounding mode.
- `req_rs1_i`, `req_rs2_i`, `req_rs3_i`  in  32 each  operand values, already read from the regfile.
- `req_rd_addr_i`  in  5  destination register.
- `fp_op_o`  out  `fpu_op_e`  to FPU; `FPU_NOP` when not executing.
- `fp_rounding_mode_o`  out  3  to FPU.
- `rs1_o`, `rs2_o`, `rs3_o`  out  32 each  to FPU.
- `rd_addr_o`  out  5  to FPU.
- `fpu_fp_write_i`, `fpu_int_write_i`  in  1 each  raw write strobes from FPU.
- `fp_regfile_write_o`, `int_regfile_write_o`  out  1 each  gated write strobes.
- `done_o`  out  1  one-cycle pulse when an operation retires.
- `busy_o`  out  1  queue non-empty or operation executing.

## Operation
- Queue:
  - Push on `req_valid_i && req_ready_o`.
  - `req_ready_o = !full`. There is no pass-through: a full queue refuses a request even if a pop happens in the same cycle.
  - Pointers have width log2(Depth)+1 and wrap modulo 2·Depth. Full when the MSBs differ and the rest are equal.
- FSM with two states:
  - IDLE:
    - `fp_op_o = FPU_NOP`.
    - If the queue is non-empty, pop the head into the execute register, load `cnt = lat(op)-1`, and go to EXEC.
  - EXEC:
    - Execute-register fields drive the FPU outputs.
    - Each cycle, `cnt` decrements.
    - When `cnt == 0` (final cycle):
      - `fp_regfile_write_o = fpu_fp_write_i`.
      - `int_regfile_write_o = fpu_int_write_i`.
      - `done_o = 1`.
      - If the queue is non-empty, pop the next op and stay in EXEC (no bubble). Otherwise go to IDLE.
    - In non-final cycles, both write outputs are forced to 0.
- Latency function:
  - `lat(FPU_DIV) = DivLatency`.
  - `lat(FPU_SQRT) = SqrtLatency`.
  - `lat(FPU_NOP) = 0`: the entry is dropped at pop with no EXEC cycle and no `done_o`.
  - All other ops: 1.
- `flush_i` has priority over every other event:
  - Queue emptied, FSM goes to IDLE, writes and `done_o` forced to 0 in that cycle.
  - A push in the same cycle is discarded.
- `busy_o = !empty || state == EXEC`.

## Timing
- Reset values: `req_ready_o=1`, `fp_op_o=FPU_NOP`, all data outputs 0, write strobes 0, `done_o=0`, `busy_o=0`, queue empty, FSM in IDLE.
- Reset mid-operation aborts the operation with no write.
- Request accepted at edge T into an empty, idle block:
  - Popped in cycle T+1 (IDLE).
  - Executes cycles T+2 … T+1+lat.
  - Write and `done_o` occur in cycle T+1+lat.
- Sustained throughput: one single-cycle op per cycle while the queue is fed.
- Operand outputs are registered and stable for every cycle of EXEC.
- Simultaneous push and final-cycle pop are both performed; occupancy is unchanged.

## Structure
- `ibex_fp_pkg` additions:
  - `fpu_seq_state_e` (IDLE, EXEC).
  - `fpu_req_t` packed struct {op, rm, rs1, rs2, rs3, rd_addr}.
  - Function `fpu_op_latency(op, DivLatency, SqrtLatency)`.
- Sub-module `ibex_fpu_req_fifo`:
  - Parameterised by `Depth` and the `fpu_req_t` type.
  - Provides push/pop/full/empty/flush.
- The sequencer instantiates the FIFO and contains the FSM, counter and strobe gating.
- `ibex_FPU` is not modified.

## Test plan
- ADD rs1=0x41200000, rs2=0x4023d70a, FPU strobe held at 1:
  - `fp_op_o=FPU_ADD` for exactly 1 cycle, two cycles after acceptance.
  - `fp_regfile_write_o` and `done_o` pulse once, in that cycle.
- DIV with DivLatency=8, FPU strobe held at 1 throughout:
  - `fp_op_o=FPU_DIV` for 8 cycles.
  - `fp_regfile_write_o` asserted only in cycle 8; exactly one `done_o`.
- Back-to-back ADD, SUB, MUL, MIN, MAX with valid held high:
  - `req_ready_o` drops when 2 entries are queued.
  - Ops execute in order on consecutive cycles with no NOP gaps.
  - 5 `done_o` pulses in total.
- Flush in cycle 4 of an 8-cycle SQRT with one ADD queued:
  - No write and no `done_o`; ADD discarded.
  - `busy_o=0` on the next cycle; `fp_op_o=FPU_NOP`.
- `rst_ni=0` for 1 cycle during a DIV:
  - All outputs at reset values the next cycle.
  - A following MAX executes normally with latency 1.
- Pointer wrap: 10 single-cycle ops with Depth=2, random valid gaps:
  - All 10 retire in order; results match a reference model.
  - No drop or duplicate entries.

Source files
------------

// File: rtl/ibex_fp_pkg.sv
// FP operation encoding and request types shared by the FPU issue sequencer.
// fpu_op_latency gives the cycles an op is held on the FPU datapath; 0 means the op is dropped.
package ibex_fp_pkg;

  typedef enum logic [3:0] {
    FPU_NOP   = 4'd0,
    FPU_ADD   = 4'd1,
    FPU_SUB   = 4'd2,
    FPU_MUL   = 4'd3,
    FPU_DIV   = 4'd4,
    FPU_SQRT  = 4'd5,
    FPU_MIN   = 4'd6,
    FPU_MAX   = 4'd7,
    FPU_FMADD = 4'd8,
    FPU_CMP   = 4'd9,
    FPU_I2F   = 4'd10,
    FPU_F2I   = 4'd11
  } fpu_op_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_EXEC = 1'b1
  } fpu_seq_state_e;

  typedef struct packed {
    fpu_op_e     op;
    logic [2:0]  rm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic [4:0]  rd_addr;
  } fpu_req_t;

  localparam int unsigned LatCntW = 16;

  function automatic logic [LatCntW-1:0] fpu_op_latency(input fpu_op_e op,
                                                         input int unsigned div_lat,
                                                         input int unsigned sqrt_lat);
    case (op)
      FPU_NOP:  return '0;
      FPU_DIV:  return LatCntW'(div_lat);
      FPU_SQRT: return LatCntW'(sqrt_lat);
      default:  return LatCntW'(1);
    endcase
  endfunction

endpackage

// File: rtl/ibex_fpu_req_fifo.sv
// In-order request queue; pointers carry an extra wrap bit so full/empty need no counter.
// Push is ignored when full, pop when empty; flush and reset empty the queue.
module ibex_fpu_req_fifo
  import ibex_fp_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = fpu_req_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  T                mem_q [Depth];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[IdxW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ibex_fpu_sequencer.sv
// Issues queued FP requests to the FPU one at a time, holding each for its fixed latency.
// Regfile write strobes and done_o are only let through on an op's final cycle.
module ibex_fpu_sequencer
  import ibex_fp_pkg::*;
#(
  parameter int unsigned Depth       = 2,
  parameter int unsigned DivLatency  = 8,
  parameter int unsigned SqrtLatency = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fpu_op_e     req_op_i,
  input  logic [2:0]  req_rm_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [31:0] req_rs3_i,
  input  logic [4:0]  req_rd_addr_i,
  output fpu_op_e     fp_op_o,
  output logic [2:0]  fp_rounding_mode_o,
  output logic [31:0] rs1_o,
  output logic [31:0] rs2_o,
  output logic [31:0] rs3_o,
  output logic [4:0]  rd_addr_o,
  input  logic        fpu_fp_write_i,
  input  logic        fpu_int_write_i,
  output logic        fp_regfile_write_o,
  output logic        int_regfile_write_o,
  output logic        done_o,
  output logic        busy_o
);

  fpu_seq_state_e      state_q, state_d;
  fpu_req_t            exec_q, head, push_data;
  logic [LatCntW-1:0]  cnt_q, head_lat;
  logic                full, empty, push, pop, final_cycle, start, commit;

  assign push_data = '{op: req_op_i, rm: req_rm_i, rs1: req_rs1_i, rs2: req_rs2_i,
                       rs3: req_rs3_i, rd_addr: req_rd_addr_i};
  assign push      = req_valid_i && req_ready_o;

  ibex_fpu_req_fifo #(
    .Depth(Depth),
    .T    (fpu_req_t)
  ) u_req_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign head_lat    = fpu_op_latency(head.op, DivLatency, SqrtLatency);
  assign final_cycle = (state_q == SEQ_EXEC) && (cnt_q == '0);
  assign pop         = !empty && !flush_i && ((state_q == SEQ_IDLE) || final_cycle);
  // A zero-latency head (NOP) is consumed by the pop but never enters EXEC.
  assign start       = pop && (head_lat != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SEQ_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (start) state_d = SEQ_EXEC;
      SEQ_EXEC: if (final_cycle) state_d = start ? SEQ_EXEC : SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
    if (flush_i) state_d = SEQ_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      exec_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      exec_q <= head;
      cnt_q  <= head_lat - 1'b1;
    end else if ((state_q == SEQ_EXEC) && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // A cycle under reset or flush must never commit, even if it is the final one.
  assign commit = final_cycle && !flush_i && rst_ni;

  always_comb begin
    fp_op_o             = FPU_NOP;
    fp_rounding_mode_o  = exec_q.rm;
    rs1_o               = exec_q.rs1;
    rs2_o               = exec_q.rs2;
    rs3_o               = exec_q.rs3;
    rd_addr_o           = exec_q.rd_addr;
    fp_regfile_write_o  = commit && fpu_fp_write_i;
    int_regfile_write_o = commit && fpu_int_write_i;
    done_o              = commit;
    if (state_q == SEQ_EXEC) fp_op_o = exec_q.op;
  end

  assign req_ready_o = !full;
  assign busy_o      = !empty || (state_q == SEQ_EXEC);

endmodule
